// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner: column drive, row synchronisation, full-scan debounce,
// and encoding of the accepted key into a one-hot digit bus and single-cycle command pulses.
module keypad_scan_encoder #(
    parameter int SCAN_DIV     = 25,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [9:0] A,
    output logic       ready,
    output logic       setup,
    output logic       sure,
    output logic       wait_t,
    output logic       fire,
    output logic       key_valid,
    output logic [3:0] key_code
);
    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam int               DEB_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CNT);
    // Key states are {valid, code}; NONE is the all-zero value.
    localparam logic [4:0]       KEY_NONE = 5'b0_0000;

    // ------------------------------------------------------------------
    // Row synchroniser (idle rows read as released)
    // ------------------------------------------------------------------
    logic [3:0] row_meta_reg;
    logic [3:0] row_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Column divider and drive
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic [1:0]       col_idx_reg;
    logic [1:0]       col_idx_next;
    logic             div_last;

    assign div_last = (div_cnt_reg == DIV_LAST);

    always_comb begin
        div_cnt_next = div_last ? '0 : div_cnt_reg + DIV_W'(1);
        col_idx_next = div_last ? col_idx_reg + 2'd1 : col_idx_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            col_idx_reg <= 2'd0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            col_idx_reg <= col_idx_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_n[gi] = (col_idx_reg != 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sample tag delayed alongside the synchroniser, so the synced rows are
    // credited to the column that was driven when they were captured.
    // ------------------------------------------------------------------
    logic [2:0] tag_d1_reg;
    logic [2:0] tag_d2_reg;
    logic       sample_en;
    logic [1:0] sample_col;
    logic       scan_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_d1_reg <= 3'd0;
            tag_d2_reg <= 3'd0;
        end else begin
            tag_d1_reg <= {div_last, col_idx_reg};
            tag_d2_reg <= tag_d1_reg;
        end
    end

    assign sample_en  = tag_d2_reg[2];
    assign sample_col = tag_d2_reg[1:0];
    assign scan_end   = sample_en && (sample_col == 2'd3);

    // ------------------------------------------------------------------
    // Snapshot: bit 4*row+col is set when that key was seen pressed
    // ------------------------------------------------------------------
    logic [15:0] snap_reg;
    logic [15:0] snap_cur;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_snap
            localparam logic [1:0] COL = 2'(gi % 4);
            assign snap_cur[gi] = (sample_en && sample_col == COL) ? ~row_sync_reg[gi / 4]
                                                                   : snap_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_reg <= 16'd0;
        end else begin
            snap_reg <= snap_cur;
        end
    end

    // Exactly one key down decodes to that key; none or several decode to NONE.
    logic [4:0] hit_cnt;
    logic [3:0] hit_code;
    logic [4:0] decoded;

    always_comb begin
        hit_cnt  = 5'd0;
        hit_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_cur[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
        decoded = (hit_cnt == 5'd1) ? {1'b1, hit_code} : KEY_NONE;
    end

    // ------------------------------------------------------------------
    // Debounce across full scans
    // ------------------------------------------------------------------
    logic [4:0]       cand_reg;
    logic [4:0]       cand_next;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic [DEB_W-1:0] deb_cnt_next;
    logic [4:0]       stable_reg;
    logic [4:0]       stable_next;
    logic             stable_upd_reg;
    logic             stable_upd_next;

    always_comb begin
        cand_next       = cand_reg;
        deb_cnt_next    = deb_cnt_reg;
        stable_next     = stable_reg;
        stable_upd_next = 1'b0;
        if (scan_end) begin
            if (decoded == cand_reg) begin
                if (deb_cnt_reg != DEB_MAX) begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end else begin
                cand_next    = decoded;
                deb_cnt_next = DEB_W'(1);
            end
            if (deb_cnt_next == DEB_MAX && cand_next != stable_reg) begin
                stable_next     = cand_next;
                stable_upd_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg       <= KEY_NONE;
            deb_cnt_reg    <= '0;
            stable_reg     <= KEY_NONE;
            stable_upd_reg <= 1'b0;
        end else begin
            cand_reg       <= cand_next;
            deb_cnt_reg    <= deb_cnt_next;
            stable_reg     <= stable_next;
            stable_upd_reg <= stable_upd_next;
        end
    end

    // ------------------------------------------------------------------
    // Output encoding, one cycle behind the stable state
    // ------------------------------------------------------------------
    logic [9:0] a_reg;
    logic [9:0] a_next;
    logic [4:0] pulse_reg;
    logic [4:0] pulse_next;
    logic       valid_reg;
    logic [3:0] code_reg;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            localparam logic [4:0] KEY = {1'b1, 4'(gi)};
            assign a_next[gi] = (stable_reg == KEY);
        end
        // Pulses only on the cycle after a change, so a held command never repeats.
        for (genvar gi = 0; gi < 5; gi++) begin : g_cmd
            localparam logic [4:0] KEY = {1'b1, 4'(gi + 10)};
            assign pulse_next[gi] = stable_upd_reg && (stable_reg == KEY);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= 10'd0;
            pulse_reg <= 5'd0;
            valid_reg <= 1'b0;
            code_reg  <= 4'd0;
        end else begin
            a_reg     <= a_next;
            pulse_reg <= pulse_next;
            valid_reg <= stable_reg[4];
            code_reg  <= stable_reg[4] ? stable_reg[3:0] : 4'd0;
        end
    end

    assign A         = a_reg;
    assign ready     = pulse_reg[0];
    assign setup     = pulse_reg[1];
    assign sure      = pulse_reg[2];
    assign wait_t    = pulse_reg[3];
    assign fire      = pulse_reg[4];
    assign key_valid = valid_reg;
    assign key_code  = code_reg;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a keypad model drives the rows, a scan-level reference model
// predicts every output each cycle, and directed scenarios pin the model with literal values.
module tb_keypad_scan_encoder;
    localparam int SD = 2;
    localparam int DB = 2;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] pressed = 16'd0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [9:0]  A;
    logic        ready, setup, sure, wait_t, fire, key_valid;
    logic [3:0]  key_code;

    int errors   = 0;
    int checks   = 0;
    int fire_cnt = 0;

    keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .A(A),
        .ready(ready), .setup(setup), .sure(sure), .wait_t(wait_t), .fire(fire),
        .key_valid(key_valid), .key_code(key_code)
    );

    always #5 clk = ~clk;

    // Physical keypad: a row reads low when a pressed key sits on the driven column.
    assign row_n = {~|(pressed[15:12] & ~col_n), ~|(pressed[11:8] & ~col_n),
                    ~|(pressed[7:4] & ~col_n), ~|(pressed[3:0] & ~col_n)};

    // ---------------- reference model ----------------
    int          cyc       = 0;
    logic [15:0] snap_m    = 16'd0;
    logic [4:0]  hist[$];
    logic [4:0]  pend_val[$];
    int          pend_due[$];
    logic [4:0]  stab_m    = 5'd0;
    logic        changed_m = 1'b0;
    logic [9:0]  exp_a     = 10'd0;
    logic [4:0]  exp_pulse = 5'd0;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_code  = 4'd0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0; snap_m = 16'd0; stab_m = 5'd0; changed_m = 1'b0;
                hist.delete(); pend_val.delete(); pend_due.delete();
                exp_a = 10'd0; exp_pulse = 5'd0; exp_valid = 1'b0; exp_code = 4'd0;
            end else begin
                int  c;
                int  n;
                int  idx;
                bit  same;
                exp_valid = stab_m[4];
                exp_code  = stab_m[4] ? stab_m[3:0] : 4'd0;
                exp_a     = (stab_m[4] && stab_m[3:0] < 4'd10) ? (10'd1 << stab_m[3:0]) : 10'd0;
                exp_pulse = (changed_m && stab_m[4] && stab_m[3:0] >= 4'd10 && stab_m[3:0] <= 4'd14)
                            ? (5'd1 << (stab_m[3:0] - 4'd10)) : 5'd0;
                changed_m = 1'b0;
                if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                    hist.push_back(pend_val[0]);
                    void'(pend_val.pop_front());
                    void'(pend_due.pop_front());
                    if (hist.size() > DB) void'(hist.pop_front());
                    if (hist.size() == DB) begin
                        same = 1'b1;
                        for (int i = 1; i < DB; i++) if (hist[i] != hist[0]) same = 1'b0;
                        if (same && hist[0] != stab_m) begin
                            stab_m = hist[0];
                            changed_m = 1'b1;
                        end
                    end
                end
                if (cyc % SD == SD - 1) begin
                    c = (cyc / SD) % 4;
                    for (int r = 0; r < 4; r++) snap_m[4*r+c] = pressed[4*r+c];
                    if (c == 3) begin
                        n = $countones(snap_m);
                        idx = 0;
                        for (int i = 0; i < 16; i++) if (snap_m[i]) idx = i;
                        pend_val.push_back(n == 1 ? {1'b1, 4'(idx)} : 5'd0);
                        pend_due.push_back(cyc + 2);
                    end
                end
                cyc++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = ~(4'd1 << ((cyc / SD) % 4));
            checks++;
            if (A !== exp_a || {fire, wait_t, sure, setup, ready} !== exp_pulse ||
                key_valid !== exp_valid || key_code !== exp_code || col_n !== exp_col) begin
                errors++;
                $display("FAIL cycle t=%0t: A=%b pulses=%b valid=%b code=%0d col_n=%b, expected A=%b pulses=%b valid=%b code=%0d col_n=%b",
                         $time, A, {fire, wait_t, sure, setup, ready}, key_valid, key_code, col_n,
                         exp_a, exp_pulse, exp_valid, exp_code, exp_col);
            end
            checks++;
            if ($countones({A, fire, wait_t, sure, setup, ready}) > 1) begin
                errors++;
                $display("FAIL exclusive t=%0t: A=%b pulses=%b, required at most one active",
                         $time, A, {fire, wait_t, sure, setup, ready});
            end
            if (fire === 1'b1) fire_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic wait_a(input string name, input logic [9:0] want, input int budget);
        int n;
        n = 0;
        while (A !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (A !== want) begin
            errors++;
            $display("FAIL %s: A=%b, required %b within %0d cycles", name, A, want, budget);
        end else begin
            $display("ok   %s: A=%b after %0d cycles", name, A, n);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] mask);
        @(negedge clk);
        pressed = mask;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int bad;
        hold(3);
        check("reset_col_n", {12'd0, col_n}, 16'h000E);
        check("reset_A", {6'd0, A}, 16'd0);
        check("reset_valid", {15'd0, key_valid}, 16'd0);
        rst_n = 1'b1;
        hold(20);

        // Digit 5: row 1, column 1
        press(16'd1 << 5);
        wait_a("d5_press", 10'b00001_00000, 27);
        hold(80);
        check("d5_hold_A", {6'd0, A}, 16'h0020);
        check("d5_code", {12'd0, key_code}, 16'd5);
        press(16'd0);
        wait_a("d5_release", 10'd0, 27);

        // Digit 0, release, digit 8
        press(16'd1 << 0);
        wait_a("d0_press", 10'b00000_00001, 27);
        press(16'd0);
        wait_a("d0_release", 10'd0, 27);
        check("d0_valid_low", {15'd0, key_valid}, 16'd0);
        press(16'd1 << 8);
        wait_a("d8_press", 10'b01000_00000, 27);
        press(16'd0);
        wait_a("d8_release", 10'd0, 27);
        hold(10);

        // Fire: row 3, column 2 -> code 14
        base = fire_cnt;
        press(16'd1 << 14);
        hold(100);
        check("fire_once", 16'(fire_cnt - base), 16'd1);
        check("fire_A_zero", {6'd0, A}, 16'd0);
        check("fire_code", {12'd0, key_code}, 16'd14);
        press(16'd0);
        hold(40);
        press(16'd1 << 14);
        hold(40);
        check("fire_twice", 16'(fire_cnt - base), 16'd2);
        press(16'd0);
        hold(40);

        // Keys 2 and 5 together read as no key
        press((16'd1 << 2) | (16'd1 << 5));
        hold(40);
        check("multi_A", {6'd0, A}, 16'd0);
        check("multi_valid", {15'd0, key_valid}, 16'd0);
        press(16'd1 << 2);
        wait_a("multi_drop5", 10'b00000_00100, 27);
        press(16'd0);
        wait_a("multi_release", 10'd0, 27);
        hold(10);

        // Bounce on digit 7: one scan pressed, one released, three times
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            press(16'd1 << 7);
            for (int j = 0; j < 7; j++) begin @(negedge clk); if (A !== 10'd0) bad++; end
            press(16'd0);
            for (int j = 0; j < 7; j++) begin @(negedge clk); if (A !== 10'd0) bad++; end
        end
        check("bounce_no_output", 16'(bad), 16'd0);
        press(16'd1 << 7);
        wait_a("bounce_stable", 10'b00100_00000, 27);
        press(16'd0);
        wait_a("bounce_release", 10'd0, 27);

        // Reset during a held digit 3
        press(16'd1 << 3);
        wait_a("d3_press", 10'b00000_01000, 27);
        #2 rst_n = 1'b0;
        #1;
        check("rst_A", {6'd0, A}, 16'd0);
        check("rst_col_n", {12'd0, col_n}, 16'h000E);
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        hold(2);
        rst_n = 1'b1;
        bad = 0;
        for (int j = 0; j < 16; j++) begin @(negedge clk); if (A !== 10'd0) bad++; end
        check("rst_redebounce_quiet", 16'(bad), 16'd0);
        wait_a("rst_redebounce", 10'b00000_01000, 11);
        press(16'd0);
        hold(30);

        // Randomised key activity checked cycle by cycle against the model
        for (int s = 0; s < 80; s++) begin
            int kind;
            logic [15:0] m;
            kind = $urandom_range(0, 99);
            if (kind < 45)      m = 16'd0;
            else if (kind < 85) m = 16'd1 << $urandom_range(0, 15);
            else                m = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            press(m);
            hold($urandom_range(1, 40));
            if ($urandom_range(0, 15) == 0) begin
                #2 rst_n = 1'b0;
                hold(2);
                rst_n = 1'b1;
            end
        end
        press(16'd0);
        hold(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
